// File: rtl/ls_unit.sv
// Load/store unit between MEM stage and data_mem.
// Serializes one access at a time; sub-dword stores are read-modify-write.
module ls_unit #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_sext,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            ld_valid,
  output logic [WORD-1:0] ld_data,
  output logic            err,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_w_data,
  input  logic [WORD-1:0] mem_r_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [WORD-1:0]   r_addr;
  logic [WORD-1:0]   r_wdata;
  logic [WORD-1:0]   r_merge_buf;
  logic [WORD-1:0]   r_ld_data;
  logic              r_ld_valid;
  logic              r_err;

  logic              w_misalign;
  logic              w_illegal;
  logic [5:0]        w_shamt;
  logic [WORD-1:0]   w_rd_shift;
  logic [WORD-1:0]   w_ext;
  logic [WORD-1:0]   w_size_mask;
  logic [WORD-1:0]   w_lane_mask;
  logic [WORD-1:0]   w_merged;

  // Alignment check of the incoming request against its size.
  always_comb begin
    w_misalign = 1'b0;
    unique case (req_size)
      2'b00: w_misalign = 1'b0;
      2'b01: w_misalign = req_addr[0];
      2'b10: w_misalign = |req_addr[1:0];
      2'b11: w_misalign = |req_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_illegal  = (req_read == req_write) || w_misalign;
  assign w_shamt    = {r_addr[2:0], 3'b000};
  assign w_rd_shift = mem_r_data >> w_shamt;

  // Extract the sized field and zero/sign-extend it for loads.
  always_comb begin
    w_ext = w_rd_shift;
    unique case (r_size)
      2'b00: w_ext = {{(WORD-8){r_sext & w_rd_shift[7]}},
                      w_rd_shift[7:0]};
      2'b01: w_ext = {{(WORD-16){r_sext & w_rd_shift[15]}},
                      w_rd_shift[15:0]};
      2'b10: w_ext = {{(WORD-32){r_sext & w_rd_shift[31]}},
                      w_rd_shift[31:0]};
      2'b11: w_ext = w_rd_shift;
      default: w_ext = w_rd_shift;
    endcase
  end

  // Byte mask covering the store width, before lane positioning.
  always_comb begin
    w_size_mask = '1;
    unique case (r_size)
      2'b00: w_size_mask = {{(WORD-8){1'b0}}, 8'hFF};
      2'b01: w_size_mask = {{(WORD-16){1'b0}}, 16'hFFFF};
      2'b10: w_size_mask = {{(WORD-32){1'b0}}, 32'hFFFF_FFFF};
      2'b11: w_size_mask = '1;
      default: w_size_mask = '1;
    endcase
  end

  assign w_lane_mask = w_size_mask << w_shamt;
  assign w_merged    = (r_merge_buf & ~w_lane_mask) |
                       ((r_wdata << w_shamt) & w_lane_mask);

  // Main FSM: captures requests, sequences accesses, registers results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge_buf <= '0;
      r_ld_data   <= '0;
      r_ld_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_err      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_size  <= req_size;
            r_sext  <= req_sext;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_illegal)
              r_err <= 1'b1;
            else if (req_read)
              r_state <= S_LOAD;
            else if (req_size == 2'b11)
              r_state <= S_STORE;
            else
              r_state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          r_ld_data  <= w_ext;
          r_ld_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_STORE: r_state <= S_IDLE;
        S_RMW_RD: begin
          r_merge_buf <= mem_r_data;
          r_state     <= S_RMW_WR;
        end
        S_RMW_WR: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign MemRead    = (r_state == S_LOAD) || (r_state == S_RMW_RD);
  assign MemWrite   = (r_state == S_STORE) || (r_state == S_RMW_WR);
  assign mem_addr   = {r_addr[WORD-1:3], 3'b000};
  assign mem_w_data = (r_state == S_STORE)  ? r_wdata  :
                      (r_state == S_RMW_WR) ? w_merged : '0;
  assign ld_valid   = r_ld_valid;
  assign ld_data    = r_ld_data;
  assign err        = r_err;

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit with a behavioural data_mem model.
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_ls_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        err;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] mem_addr;
  logic [63:0] mem_w_data;
  logic [63:0] mem_r_data;

  logic [63:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  ls_unit #(.WORD(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .err        (err),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_addr[10:3]];

  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[10:3]] <= mem_w_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sx,
                       input logic [63:0] a, input logic [63:0] wd);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("issue_ready", {63'd0, req_ready}, 64'd1);
    req_read  = rd;
    req_write = wr;
    req_size  = sz;
    req_sext  = sx;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz,
                         input logic sx, input logic [63:0] a,
                         input logic [63:0] exp);
    issue(1'b1, 1'b0, sz, sx, a, 64'd0);
    chk({tag, "_memread"}, {63'd0, MemRead}, 64'd1);
    chk({tag, "_memaddr"}, mem_addr, {a[63:3], 3'b000});
    chk({tag, "_busy"}, {63'd0, req_ready}, 64'd0);
    step();
    chk({tag, "_ldvalid"}, {63'd0, ld_valid}, 64'd1);
    chk({tag, "_lddata"}, ld_data, exp);
    chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_rddone"}, {63'd0, MemRead}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    mem[8]  = 64'd8;
    mem[16] = 64'd16;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_sext  = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    #12;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_memread", {63'd0, MemRead}, 64'd0);
    chk("rst_memwrite", {63'd0, MemWrite}, 64'd0);
    chk("rst_ldvalid", {63'd0, ld_valid}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_lddata", ld_data, 64'd0);
    chk("rst_wdata", mem_w_data, 64'd0);
    rst = 1'b0;
    step();

    do_load("ld64", 2'b11, 1'b0, 64'd64, 64'd8);
    step();
    chk("ld64_pulse", {63'd0, ld_valid}, 64'd0);

    issue(1'b0, 1'b1, 2'b00, 1'b0, 64'd67, 64'hAB);
    chk("sb_rd", {63'd0, MemRead}, 64'd1);
    chk("sb_nowr", {63'd0, MemWrite}, 64'd0);
    step();
    chk("sb_wr", {63'd0, MemWrite}, 64'd1);
    chk("sb_rdoff", {63'd0, MemRead}, 64'd0);
    chk("sb_wdata", mem_w_data, 64'h0000_0000_AB00_0008);
    chk("sb_busy", {63'd0, req_ready}, 64'd0);
    step();
    chk("sb_ready", {63'd0, req_ready}, 64'd1);

    do_load("ld64b", 2'b11, 1'b0, 64'd64, 64'h0000_0000_AB00_0008);
    do_load("lb_s", 2'b00, 1'b1, 64'd67, 64'hFFFF_FFFF_FFFF_FFAB);
    do_load("lb_z", 2'b00, 1'b0, 64'd67, 64'h0000_0000_0000_00AB);
    do_load("lh_s", 2'b01, 1'b1, 64'd66, 64'hFFFF_FFFF_FFFF_AB00);
    do_load("ld_sx", 2'b11, 1'b1, 64'd64, 64'h0000_0000_AB00_0008);

    issue(1'b1, 1'b0, 2'b10, 1'b0, 64'd66, 64'd0);
    chk("mis_err", {63'd0, err}, 64'd1);
    chk("mis_rd", {63'd0, MemRead}, 64'd0);
    chk("mis_wr", {63'd0, MemWrite}, 64'd0);
    chk("mis_ready", {63'd0, req_ready}, 64'd1);
    step();
    chk("mis_pulse", {63'd0, err}, 64'd0);
    chk("mis_noload", {63'd0, ld_valid}, 64'd0);

    issue(1'b1, 1'b1, 2'b11, 1'b0, 64'd64, 64'd99);
    chk("rw_err", {63'd0, err}, 64'd1);
    chk("rw_wr", {63'd0, MemWrite}, 64'd0);
    step();
    chk("rw_mem", mem[8], 64'h0000_0000_AB00_0008);

    issue(1'b0, 1'b1, 2'b11, 1'b0, 64'd64, 64'd13);
    chk("sd_wr", {63'd0, MemWrite}, 64'd1);
    chk("sd_wdata", mem_w_data, 64'd13);
    chk("sd_busy", {63'd0, req_ready}, 64'd0);
    do_load("ld13", 2'b11, 1'b0, 64'd64, 64'd13);

    issue(1'b0, 1'b1, 2'b01, 1'b0, 64'd70, 64'hFFFF_1234);
    step();
    chk("sh_wdata", mem_w_data, 64'h1234_0000_0000_000D);
    step();
    do_load("lw68", 2'b10, 1'b1, 64'd68, 64'h0000_0000_1234_0000);

    issue(1'b0, 1'b1, 2'b01, 1'b0, 64'd128, 64'hBEEF);
    chk("rmw_rd", {63'd0, MemRead}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr", {63'd0, MemWrite}, 64'd0);
    chk("arst_ready", {63'd0, req_ready}, 64'd1);
    chk("arst_rd", {63'd0, MemRead}, 64'd0);
    step();
    chk("arst_wr2", {63'd0, MemWrite}, 64'd0);
    rst = 1'b0;
    step();
    chk("arst_wr3", {63'd0, MemWrite}, 64'd0);
    chk("arst_ldv", {63'd0, ld_valid}, 64'd0);
    do_load("ld128", 2'b11, 1'b0, 64'd128, 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
